mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles (legal 1..7).

REQ-002 Ports (name  direction  width  meaning), one per line:
- clock  in  1  sole clock, rising edge.
- resetn  in  1  reset; synchronous, active-low.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  CPU write enable, 1=write.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse to CPU.
- cpu_rdata  out  DATA_W  CPU read data, valid while cpu_ack=1.
- vga_req  in  1  display fetch request, read-only; held until vga_ack.
- vga_addr  in  ADDR_W  display fetch address.
- vga_ack  out  1  one-cycle completion pulse to display fetcher.
- vga_rdata  out  DATA_W  display read data, valid while vga_ack=1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  synchronous memory read data, valid MEM_LAT cycles after the mem_en cycle.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-004 IDLE -> ISSUE when cpu_req|vga_req; otherwise stay in IDLE.
REQ-005 In the IDLE->ISSUE cycle the arbiter SHALL latch grant, address, we and wdata from the winner; the requester's fields need only be valid in that cycle.
REQ-006 Single request: that requester SHALL win.
REQ-007 Both requesting: the requester not recorded in last_grant SHALL win; last_grant updates to the winner.
REQ-008 ISSUE SHALL last exactly 1 cycle with mem_en=1 and mem_addr/mem_wdata from the latches. mem_we=1 only for a latched CPU write; a VGA grant SHALL force mem_we=0.
REQ-009 Outside ISSUE, mem_en=0 and mem_we=0.
REQ-010 WAIT SHALL last exactly MEM_LAT cycles, counted by a 3-bit counter.
REQ-011 On the edge ending the last WAIT cycle, mem_rdata SHALL load into the granted requester's rdata register only; the other requester's rdata register is unchanged.
REQ-012 RESP SHALL last 1 cycle with only the granted requester's ack=1; then IDLE.
REQ-013 Read latency with MEM_LAT=1: req seen in IDLE cycle N -> ISSUE N+1 -> WAIT N+2 -> ack N+3. Writes SHALL use the same timing and also update rdata (value unused).
REQ-014 The arbiter SHALL ignore requests outside IDLE; a requester that deasserts req early SHALL still receive its ack.
REQ-015 A req still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-016 At most one ack SHALL be high in any cycle; acks never occur outside RESP.

Reset
REQ-017 While resetn=0 at a rising edge, the block SHALL set: state=IDLE, last_grant=VGA (CPU wins first tie), counter=0, all latches=0, cpu_rdata=vga_rdata=0, and all acks=0.
REQ-018 Reset mid-transaction SHALL abort without ack; a memory write already issued is not undone.
REQ-019 mem_en/mem_we SHALL be 0 in the first cycle after reset.

Structure
REQ-020 Package mem_arb_pkg SHALL hold the state encoding, the GRANT_CPU/GRANT_VGA constants and the default parameter values.
REQ-021 The 2-way round-robin selector SHALL be sub-module rr_arb2 (inputs req[1:0], last; output grant). The FSM, counter and latches stay in mem_arbiter.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- CPU read alone, addr=0x10, memory[0x10]=0xDEADBEEF, MEM_LAT=1 -> mem_en at N+1; cpu_ack and cpu_rdata=0xDEADBEEF at N+3; vga_rdata unchanged.
- CPU write addr=0x20 data=0x12345678 -> a single mem_en/mem_we cycle with those values; cpu_ack 2 cycles later; readback returns 0x12345678.
- cpu_req and vga_req both high from reset and held, then reasserted after each ack -> grants alternate CPU, VGA, CPU, VGA; never two acks in one cycle.
- MEM_LAT=3, VGA read -> vga_ack exactly 5 cycles after the IDLE request cycle.
- resetn=0 asserted during WAIT -> no ack; state IDLE; mem_en=0; rdata outputs 0.
- vga_req dropped during ISSUE -> vga_ack still pulses once; no further grant.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the CPU/display memory arbiter: FSM encoding, grant ids, defaults.
// No logic here; latency and backpressure are properties of mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_VGA = 1'b1;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_MEM_LAT = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick (bit 0 = CPU, bit 1 = display); purely combinational, zero latency.
// On a tie the requester that did not win last time goes first; no backpressure of its own.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = GRANT_CPU;
        if (req == 2'b11) begin
            grant = ~last;
        end else if (req[1]) begin
            grant = GRANT_VGA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory between a CPU port and a read-only display port, one access at a time.
// Request to ack is MEM_LAT+2 cycles; requests arriving outside IDLE wait, held req lines are the backpressure.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              vga_ack_q, vga_ack_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              arb_grant;

    rr_arb2 u_rr_arb2 (
        .req   ({vga_req, cpu_req}),
        .last  (last_grant_q),
        .grant (arb_grant)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        vga_rdata_d  = vga_rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || vga_req) begin
                    state_d      = ISSUE;
                    grant_d      = arb_grant;
                    last_grant_d = arb_grant;
                    if (arb_grant == GRANT_CPU) begin
                        addr_d  = cpu_addr;
                        we_d    = cpu_we;
                        wdata_d = cpu_wdata;
                    end else begin
                        // display fetches are read-only, so never carry a write
                        addr_d  = vga_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = 3'd0;
            end
            WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = RESP;
                    cnt_d   = 3'd0;
                    if (grant_q == GRANT_CPU) begin
                        cpu_rdata_d = mem_rdata;
                    end else begin
                        vga_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes and acks are registered from the next state so they line up with it.
        mem_en_d  = (state_d == ISSUE);
        mem_we_d  = (state_d == ISSUE) && we_d;
        cpu_ack_d = (state_d == RESP) && (grant_d == GRANT_CPU);
        vga_ack_d = (state_d == RESP) && (grant_d == GRANT_VGA);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= GRANT_CPU;
            last_grant_q <= GRANT_VGA;
            cnt_q        <= 3'd0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            vga_rdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            vga_ack_q    <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vga_rdata_q  <= vga_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            vga_ack_q    <= vga_ack_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign vga_ack   = vga_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vga_rdata = vga_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3, each with its own memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetn;
    logic        cpu_req, cpu_we, cpu_ack, vga_req, vga_ack, mem_en, mem_we;
    logic [7:0]  cpu_addr, vga_addr, mem_addr;
    logic [31:0] cpu_wdata, cpu_rdata, vga_rdata, mem_wdata, mem_rdata;

    logic        cpu_req3, cpu_we3, cpu_ack3, vga_req3, vga_ack3, mem_en3, mem_we3;
    logic [7:0]  cpu_addr3, vga_addr3, mem_addr3;
    logic [31:0] cpu_wdata3, cpu_rdata3, vga_rdata3, mem_wdata3, mem_rdata3;

    logic        pre_we;
    logic [7:0]  pre_a;
    logic [31:0] pre_d;
    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic [31:0] p1;
    logic [31:0] p3 [0:2];

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1)) u_dut (
        .clock(clock), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack), .vga_rdata(vga_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
        .clock(clock), .resetn(resetn),
        .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
        .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
        .vga_req(vga_req3), .vga_addr(vga_addr3), .vga_ack(vga_ack3), .vga_rdata(vga_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3)
    );

    // Synchronous memories: read data appears MEM_LAT cycles after the address is presented.
    always @(posedge clock) begin
        if (pre_we) begin
            mem1[pre_a] <= pre_d;
            mem3[pre_a] <= pre_d;
        end else begin
            if (mem_en && mem_we)   mem1[mem_addr]  <= mem_wdata;
            if (mem_en3 && mem_we3) mem3[mem_addr3] <= mem_wdata3;
        end
        p1    <= mem1[mem_addr];
        p3[0] <= mem3[mem_addr3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_rdata  = p1;
    assign mem_rdata3 = p3[2];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        tick();
        pre_we = 1'b0;
    endtask

    initial begin
        int          nack;
        int          lat;
        int          acks;
        int          ens;
        int          cacks;
        logic        found;
        logic        any_ack;
        logic [1:0]  seq [0:3];
        logic [1:0]  exp_seq [0:3];

        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        seq     = '{2'b00, 2'b00, 2'b00, 2'b00};

        resetn   = 1'b0;
        pre_we   = 1'b0; pre_a = 8'h00; pre_d = 32'h0;
        cpu_req  = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 32'h0;
        vga_req  = 1'b0; vga_addr = 8'h00;
        cpu_req3 = 1'b0; cpu_we3 = 1'b0; cpu_addr3 = 8'h00; cpu_wdata3 = 32'h0;
        vga_req3 = 1'b0; vga_addr3 = 8'h00;
        tick();
        preload(8'h10, 32'hDEADBEEF);
        preload(8'h30, 32'hAAAA0030);
        preload(8'h40, 32'hBBBB0040);
        preload(8'h50, 32'hCAFEF00D);
        tick();

        check("rst_cpu_ack",   {31'b0, cpu_ack}, 32'h0);
        check("rst_vga_ack",   {31'b0, vga_ack}, 32'h0);
        check("rst_mem_en",    {31'b0, mem_en},  32'h0);
        check("rst_mem_we",    {31'b0, mem_we},  32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_vga_rdata", vga_rdata, 32'h0);
        check("rst_state",     32'(u_dut.state_q), 32'(IDLE));
        resetn = 1'b1;
        tick();
        check("post_rst_mem_en", {31'b0, mem_en}, 32'h0);

        // CPU read alone
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        tick();
        check("rd_issue_en",   {31'b0, mem_en}, 32'h1);
        check("rd_issue_we",   {31'b0, mem_we}, 32'h0);
        check("rd_issue_addr", {24'b0, mem_addr}, 32'h10);
        tick();
        check("rd_wait_en",  {31'b0, mem_en},  32'h0);
        check("rd_wait_ack", {31'b0, cpu_ack}, 32'h0);
        tick();
        check("rd_ack",       {31'b0, cpu_ack}, 32'h1);
        check("rd_rdata",     cpu_rdata, 32'hDEADBEEF);
        check("rd_vga_rdata", vga_rdata, 32'h0);
        check("rd_vga_ack",   {31'b0, vga_ack}, 32'h0);
        cpu_req = 1'b0;
        tick();
        check("rd_ack_pulse", {31'b0, cpu_ack}, 32'h0);

        // CPU write, then read back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 32'h12345678;
        tick();
        check("wr_en",    {31'b0, mem_en}, 32'h1);
        check("wr_we",    {31'b0, mem_we}, 32'h1);
        check("wr_addr",  {24'b0, mem_addr}, 32'h20);
        check("wr_wdata", mem_wdata, 32'h12345678);
        tick();
        check("wr_single_en", {31'b0, mem_en}, 32'h0);
        check("wr_single_we", {31'b0, mem_we}, 32'h0);
        tick();
        check("wr_ack", {31'b0, cpu_ack}, 32'h1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_addr = 8'h20;
        tick(); tick(); tick();
        check("rb_ack",   {31'b0, cpu_ack}, 32'h1);
        check("rb_rdata", cpu_rdata, 32'h12345678);
        cpu_req = 1'b0;
        tick();

        // Both requesting from reset: grants must alternate, CPU first
        resetn = 1'b0;
        cpu_req = 1'b1; cpu_addr = 8'h30;
        vga_req = 1'b1; vga_addr = 8'h40;
        tick(); tick();
        check("tie_rst_cpu_rdata", cpu_rdata, 32'h0);
        check("tie_rst_mem_en",    {31'b0, mem_en}, 32'h0);
        resetn = 1'b1;
        nack = 0;
        for (int c = 0; c < 40 && nack < 4; c++) begin
            tick();
            check("tie_one_ack", {31'b0, cpu_ack & vga_ack}, 32'h0);
            if (cpu_ack || vga_ack) begin
                seq[nack] = {vga_ack, cpu_ack};
                if (cpu_ack) check("tie_cpu_rdata", cpu_rdata, 32'hAAAA0030);
                else         check("tie_vga_rdata", vga_rdata, 32'hBBBB0040);
                nack++;
            end
        end
        check("tie_ack_count", nack, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tie_order_%0d", i), {30'b0, seq[i]}, {30'b0, exp_seq[i]});
        end
        cpu_req = 1'b0; vga_req = 1'b0;
        tick(); tick();

        // MEM_LAT=3 display read
        vga_req3 = 1'b1; vga_addr3 = 8'h50;
        lat = 0; found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            tick();
            lat++;
            if (vga_ack3) found = 1'b1;
        end
        check("lat3_cycles",    lat, 5);
        check("lat3_vga_rdata", vga_rdata3, 32'hCAFEF00D);
        check("lat3_cpu_rdata", cpu_rdata3, 32'h0);
        vga_req3 = 1'b0;
        tick();

        // Reset while waiting on memory
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        tick(); tick();
        check("abort_in_wait", 32'(u_dut.state_q), 32'(WAIT));
        resetn = 1'b0; cpu_req = 1'b0;
        tick();
        check("abort_ack",       {31'b0, cpu_ack}, 32'h0);
        check("abort_state",     32'(u_dut.state_q), 32'(IDLE));
        check("abort_mem_en",    {31'b0, mem_en}, 32'h0);
        check("abort_cpu_rdata", cpu_rdata, 32'h0);
        check("abort_vga_rdata", vga_rdata, 32'h0);
        resetn = 1'b1;
        any_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            any_ack = any_ack | cpu_ack | vga_ack;
        end
        check("abort_no_late_ack", {31'b0, any_ack}, 32'h0);

        // Display drops its request during ISSUE
        vga_req = 1'b1; vga_addr = 8'h40; cpu_we = 1'b1;
        tick();
        check("drop_issue_en",   {31'b0, mem_en}, 32'h1);
        check("drop_issue_we",   {31'b0, mem_we}, 32'h0);
        check("drop_issue_addr", {24'b0, mem_addr}, 32'h40);
        vga_req = 1'b0; cpu_we = 1'b0;
        acks = 0; ens = 0; cacks = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            acks  += int'(vga_ack);
            ens   += int'(mem_en);
            cacks += int'(cpu_ack);
        end
        check("drop_vga_acks",  acks, 1);
        check("drop_no_regrant", ens, 0);
        check("drop_cpu_acks",  cacks, 0);
        check("drop_vga_rdata", vga_rdata, 32'hBBBB0040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
